// File: rtl/core_pkg.sv
// core_pkg: shared funct3 codes and load/store FSM state encoding
package core_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store byte-lane steering/enables and load extraction with sign/zero extension
module lsu_align
  import core_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  a,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] ld_data
);
  logic [31:0] sh;
  always_comb begin
    sh = rdata >> {a, 3'b000};
    be = !we ? 4'hf : funct3 == F3_B ? 4'b0001 << a : funct3 == F3_H ? (a[1] ? 4'b1100 : 4'b0011) : 4'hf;
    wdata_lane = !we ? 32'h0 : funct3 == F3_B ? {4{wdata[7:0]}} : funct3 == F3_H ? {2{wdata[15:0]}} : wdata;
    ld_data = funct3 == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
              funct3 == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
              funct3 == F3_BU ? {24'h0, sh[7:0]} :
              funct3 == F3_HU ? {16'h0, sh[15:0]} : sh;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store stage over a valid/ack bus with timeout; MISALIGN_TRAP_EN traps misaligned accesses instead of aligning them
module mem_access_unit
  import core_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);
  state_t      state;
  logic        we_r, err_r, bad, misal, half, word;
  logic [2:0]  f3_r;
  logic [31:0] addr_r, wdata_r, rdata_r, lane_wdata, ld_data;
  logic [3:0]  lane_be;
  logic [1:0]  a_in;
  logic [7:0]  cnt;
  lsu_align u_align (
    .we(we_r), .funct3(f3_r), .a(addr_r[1:0]), .wdata(wdata_r), .rdata(dmem_rdata),
    .be(lane_be), .wdata_lane(lane_wdata), .ld_data(ld_data)
  );
  always_comb begin
    half = req_funct3[1:0] == 2'b01;
    word = req_funct3[1:0] == 2'b10;
    bad = req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11 || (req_we && req_funct3[2]);
`ifdef MISALIGN_TRAP_EN
    misal = (half && req_addr[0]) || (word && req_addr[1:0] != 2'b00);
    a_in = req_addr[1:0];
`else
    misal = 1'b0;
    a_in = word ? 2'b00 : half ? {req_addr[1], 1'b0} : req_addr[1:0];
`endif
    req_ready = state == IDLE;
    dmem_req = state == BUSY;
    dmem_we = dmem_req && we_r;
    dmem_addr = dmem_req ? {addr_r[31:2], 2'b00} : 32'h0;
    dmem_be = dmem_req ? lane_be : 4'h0;
    dmem_wdata = dmem_req ? lane_wdata : 32'h0;
    resp_valid = state == RESP;
    resp_rdata = resp_valid ? rdata_r : 32'h0;
    resp_err = resp_valid && err_r;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      we_r <= 1'b0;
      f3_r <= '0;
      addr_r <= '0;
      wdata_r <= '0;
      rdata_r <= '0;
      err_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we_r <= req_we;
          f3_r <= req_funct3;
          addr_r <= {req_addr[31:2], a_in};
          wdata_r <= req_wdata;
          cnt <= '0;
          rdata_r <= '0;
          err_r <= bad || misal;
          state <= (bad || misal) ? RESP : BUSY;
        end
        BUSY: if (dmem_ack) begin
          rdata_r <= we_r ? 32'h0 : ld_data;
          state <= RESP;
        end else if (cnt == 8'(TIMEOUT_CYC - 1)) begin
          err_r <= 1'b1;
          state <= RESP;
        end else begin
          cnt <= cnt + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
